// File: rtl/wb_ram_slave.sv
// ---------------------------------------------------------------------------
// wb_ram_slave
//
// Wishbone B4 classic single-port RAM responder. One request is accepted
// from IDLE, optionally held for WAIT_STATES extra cycles, then answered
// with a single-cycle registered ack_o (or err_o). Writes honour the byte
// lane enables; reads return masked lanes as 0x00.
//
// Parameters:
//   ADDR_WIDTH  - byte address width; top 4 bits are the interconnect slave
//                 select and are ignored by this block.
//   DATA_WIDTH  - data bus width, multiple of 8.
//   MEM_WORDS   - RAM depth in words, power of two (at least 2).
//   WAIT_STATES - extra cycles between request sample and response, 0..15.
//
// Ports:
//   clk_i  - clock, rising edge.
//   rst_i  - synchronous active-high reset.
//   cyc_i  - bus cycle valid.
//   stb_i  - strobe, this slave selected.
//   we_i   - 1 = write, 0 = read.
//   adr_i  - byte address.
//   dat_i  - write data.
//   sel_i  - byte lane enables.
//   dat_o  - registered read data, held until the next read response.
//   ack_o  - normal termination, one cycle wide.
//   err_o  - error termination, one cycle wide.
//
// Optional feature (macro WB_RAM_SLAVE_ERR_EN):
//   defined   - a word index at or beyond MEM_WORDS terminates with err_o,
//               performs no write and returns zero read data.
//   undefined - err_o is tied low and the word index wraps modulo MEM_WORDS.
// ---------------------------------------------------------------------------
module wb_ram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int SEL_BITS = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
    localparam int IDX_W    = ADDR_WIDTH - 4 - SEL_BITS;
    localparam int MEM_AW   = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, next_state;

    logic [3:0]            wait_cnt, wait_cnt_next;
    logic                  capture;
    logic                  finish;

    logic [IDX_W-1:0]      lat_idx;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic [SEL_WIDTH-1:0]  lat_sel;

    logic [DATA_WIDTH-1:0] dat_q;
    logic                  ack_q;
    logic                  out_of_range;

    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [DATA_WIDTH-1:0] read_data;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // The slave-select bits and the sub-word byte offset never reach the
    // datapath; the word index is taken from the middle of the address.
    logic unused_adr;
    assign unused_adr = ^adr_i;

    logic [IDX_W-1:0] idx_in;
    assign idx_in = adr_i[ADDR_WIDTH-5:SEL_BITS];

    // Low index bits address the RAM directly, which gives the wrap
    // behaviour for free when range errors are disabled.
    assign mem_addr = lat_idx[MEM_AW-1:0];
    assign mem_word = mem[mem_addr];

`ifdef WB_RAM_SLAVE_ERR_EN
    logic [IDX_W-1:0] idx_hi;
    logic             err_q;

    // Any set bit above the RAM address range means the index is too big.
    assign idx_hi       = lat_idx >> MEM_AW;
    assign out_of_range = |idx_hi;
    assign err_o        = err_q;
`else
    logic unused_idx;
    assign unused_idx   = ^(lat_idx >> MEM_AW);
    assign out_of_range = 1'b0;
    assign err_o        = 1'b0;
`endif

    assign ack_o = ack_q;
    assign dat_o = dat_q;

    // Read data for the pending request: disabled lanes read as zero, and a
    // rejected out-of-range access returns all zeros.
    always_comb begin
        read_data = '0;
        if (!out_of_range) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (lat_sel[b]) begin
                    read_data[8*b +: 8] = mem_word[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic. The counter is loaded with WAIT_STATES when a request
    // is taken and the FSM moves from WAIT to RESP on the edge where it is 1,
    // so RESP is the final cycle before the response edge. The response
    // (ack/err, write commit, read capture) is issued on the edge leaving
    // RESP, which lands the ack WAIT_STATES+1 edges after the request edge.
    // A request is only sampled in IDLE, so a strobe held through RESP is
    // not re-taken until the ack cycle itself.
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    capture       = 1'b1;
                    wait_cnt_next = 4'(WAIT_STATES);
                    next_state    = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    next_state    = IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt == 4'd1) begin
                    next_state    = RESP;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // State, request latches and registered response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lat_idx  <= '0;
            lat_we   <= 1'b0;
            lat_dat  <= '0;
            lat_sel  <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            if (capture) begin
                lat_idx <= idx_in;
                lat_we  <= we_i;
                lat_dat <= dat_i;
                lat_sel <= sel_i;
            end
            ack_q <= finish && !out_of_range;
            if (finish && !lat_we) begin
                dat_q <= read_data;
            end
        end
    end

`ifdef WB_RAM_SLAVE_ERR_EN
    // Error pulse, mutually exclusive with ack by construction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= finish && out_of_range;
        end
    end
`endif

    // RAM array. Contents survive reset; reset only suppresses a write that
    // would otherwise commit on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && finish && lat_we && !out_of_range) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (lat_sel[b]) begin
                    mem[mem_addr][8*b +: 8] <= lat_dat[8*b +: 8];
                end
            end
        end
    end

endmodule
